// File: rtl/tbus_arbiter.sv
// ----------------------------------------------------------------------------
// tbus_arbiter
// Two-master (icache, dcache) to one-slave (DDR) arbiter on the trinity bus.
// One transaction is outstanding at a time, and contention is resolved
// round-robin. The request payload is registered at grant and replayed to
// DDR. Read data and a one-cycle done pulse go back to the owning master only.
//
// Ports
//   clock, reset_n                  clock, asynchronous active-low reset
//   icache2arb_tbus_*               icache request / response channel
//   dcache2arb_tbus_*               dcache request / response channel
//   arb2ddr_tbus_*                  DDR request / response channel
//   arb_timeout_err                 sticky watchdog error
//
// Build option
//   TBUS_ARB_TIMEOUT_EN  enables the REQ/WAIT watchdog. The limit is
//                        TIMEOUT_CYCLES. When the macro is undefined,
//                        arb_timeout_err is tied low.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; grant a requester, ready is high combinationally
// REQ    | arb2ddr valid high with latched payload, waiting for DDR ready
// WAIT   | DDR accepted, waiting for DDR done
// RESP   | owner's done pulse, read data already captured
// ----------------------------------------------------------------------------
module tbus_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int OP_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset_n,

   input  logic                  icache2arb_tbus_index_valid,
   output logic                  icache2arb_tbus_index_ready,
   input  logic [ADDR_WIDTH-1:0] icache2arb_tbus_index,
   input  logic [DATA_WIDTH-1:0] icache2arb_tbus_write_data,
   input  logic [DATA_WIDTH-1:0] icache2arb_tbus_write_mask,
   input  logic [OP_WIDTH-1:0]   icache2arb_tbus_operation_type,
   output logic [DATA_WIDTH-1:0] icache2arb_tbus_read_data,
   output logic                  icache2arb_tbus_operation_done,

   input  logic                  dcache2arb_tbus_index_valid,
   output logic                  dcache2arb_tbus_index_ready,
   input  logic [ADDR_WIDTH-1:0] dcache2arb_tbus_index,
   input  logic [DATA_WIDTH-1:0] dcache2arb_tbus_write_data,
   input  logic [DATA_WIDTH-1:0] dcache2arb_tbus_write_mask,
   input  logic [OP_WIDTH-1:0]   dcache2arb_tbus_operation_type,
   output logic [DATA_WIDTH-1:0] dcache2arb_tbus_read_data,
   output logic                  dcache2arb_tbus_operation_done,

   output logic                  arb2ddr_tbus_index_valid,
   input  logic                  arb2ddr_tbus_index_ready,
   output logic [ADDR_WIDTH-1:0] arb2ddr_tbus_index,
   output logic [DATA_WIDTH-1:0] arb2ddr_tbus_write_data,
   output logic [DATA_WIDTH-1:0] arb2ddr_tbus_write_mask,
   output logic [OP_WIDTH-1:0]   arb2ddr_tbus_operation_type,
   input  logic [DATA_WIDTH-1:0] arb2ddr_tbus_read_data,
   input  logic                  arb2ddr_tbus_operation_done,

   output logic                  arb_timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t                state, state_nxt;
   logic                  owner_d;        // 1: dcache owns the transaction
   logic                  last_grant_d;   // 1: dcache was granted last
   logic                  grant_i, grant_d;
   logic                  rd_capture, rd_timeout;
   logic                  to_hit;
   logic [DATA_WIDTH-1:0] rd_val;

   always_comb begin
      state_nxt  = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      rd_capture = 1'b0;
      rd_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            // Gate on reset_n so ready stays low while reset is asserted.
            if (reset_n) begin
               if (icache2arb_tbus_index_valid &&
                   (!dcache2arb_tbus_index_valid || last_grant_d))
                  grant_i = 1'b1;
               else if (dcache2arb_tbus_index_valid)
                  grant_d = 1'b1;
               if (grant_i || grant_d)
                  state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // A done without ready is not a completion of our request.
            if (arb2ddr_tbus_index_ready && arb2ddr_tbus_operation_done) begin
               rd_capture = 1'b1;
               state_nxt  = S_RESP;
            end else if (to_hit) begin
               rd_timeout = 1'b1;
               state_nxt  = S_RESP;
            end else if (arb2ddr_tbus_index_ready) begin
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (arb2ddr_tbus_operation_done) begin
               rd_capture = 1'b1;
               state_nxt  = S_RESP;
            end else if (to_hit) begin
               rd_timeout = 1'b1;
               state_nxt  = S_RESP;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rd_val = rd_timeout ? '1 : arb2ddr_tbus_read_data;

   assign icache2arb_tbus_index_ready    = grant_i;
   assign dcache2arb_tbus_index_ready    = grant_d;
   assign icache2arb_tbus_operation_done = (state == S_RESP) && !owner_d;
   assign dcache2arb_tbus_operation_done = (state == S_RESP) &&  owner_d;
   assign arb2ddr_tbus_index_valid       = (state == S_REQ);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                       <= S_IDLE;
         owner_d                     <= 1'b0;
         last_grant_d                <= 1'b1;
         arb2ddr_tbus_index          <= '0;
         arb2ddr_tbus_write_data     <= '0;
         arb2ddr_tbus_write_mask     <= '0;
         arb2ddr_tbus_operation_type <= '0;
         icache2arb_tbus_read_data   <= '0;
         dcache2arb_tbus_read_data   <= '0;
      end else begin
         state <= state_nxt;
         if (grant_i) begin
            arb2ddr_tbus_index          <= icache2arb_tbus_index;
            arb2ddr_tbus_write_data     <= icache2arb_tbus_write_data;
            arb2ddr_tbus_write_mask     <= icache2arb_tbus_write_mask;
            arb2ddr_tbus_operation_type <= icache2arb_tbus_operation_type;
            owner_d                     <= 1'b0;
            last_grant_d                <= 1'b0;
         end else if (grant_d) begin
            arb2ddr_tbus_index          <= dcache2arb_tbus_index;
            arb2ddr_tbus_write_data     <= dcache2arb_tbus_write_data;
            arb2ddr_tbus_write_mask     <= dcache2arb_tbus_write_mask;
            arb2ddr_tbus_operation_type <= dcache2arb_tbus_operation_type;
            owner_d                     <= 1'b1;
            last_grant_d                <= 1'b1;
         end
         if (rd_capture || rd_timeout) begin
            if (owner_d) dcache2arb_tbus_read_data <= rd_val;
            else         icache2arb_tbus_read_data <= rd_val;
         end
      end
   end

`ifdef TBUS_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   // Down-counter: reloaded while idle, terminal count after
   // TIMEOUT_CYCLES cycles spent in REQ/WAIT.
   logic [CW-1:0] to_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         to_cnt <= '0;
      else if (state == S_IDLE)
         to_cnt <= TO_LAST;
      else if (((state == S_REQ) || (state == S_WAIT)) && (to_cnt != '0))
         to_cnt <= to_cnt - 1'b1;
   end

   assign to_hit = ((state == S_REQ) || (state == S_WAIT)) && (to_cnt == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         arb_timeout_err <= 1'b0;
      else if (rd_timeout)
         arb_timeout_err <= 1'b1;
   end
`else
   assign to_hit          = 1'b0;
   assign arb_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_tbus_arbiter.sv
module tb_tbus_arbiter;

   localparam int TO_CYC = 16;

   logic        clock;
   logic        reset_n;
   logic        icache2arb_tbus_index_valid, icache2arb_tbus_index_ready;
   logic [63:0] icache2arb_tbus_index, icache2arb_tbus_write_data, icache2arb_tbus_write_mask;
   logic [1:0]  icache2arb_tbus_operation_type;
   logic [63:0] icache2arb_tbus_read_data;
   logic        icache2arb_tbus_operation_done;
   logic        dcache2arb_tbus_index_valid, dcache2arb_tbus_index_ready;
   logic [63:0] dcache2arb_tbus_index, dcache2arb_tbus_write_data, dcache2arb_tbus_write_mask;
   logic [1:0]  dcache2arb_tbus_operation_type;
   logic [63:0] dcache2arb_tbus_read_data;
   logic        dcache2arb_tbus_operation_done;
   logic        arb2ddr_tbus_index_valid, arb2ddr_tbus_index_ready;
   logic [63:0] arb2ddr_tbus_index, arb2ddr_tbus_write_data, arb2ddr_tbus_write_mask;
   logic [1:0]  arb2ddr_tbus_operation_type;
   logic [63:0] arb2ddr_tbus_read_data;
   logic        arb2ddr_tbus_operation_done;
   logic        arb_timeout_err;

   tbus_arbiter #(
      .ADDR_WIDTH(64), .DATA_WIDTH(64), .OP_WIDTH(2), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clock                          (clock),
      .reset_n                        (reset_n),
      .icache2arb_tbus_index_valid    (icache2arb_tbus_index_valid),
      .icache2arb_tbus_index_ready    (icache2arb_tbus_index_ready),
      .icache2arb_tbus_index          (icache2arb_tbus_index),
      .icache2arb_tbus_write_data     (icache2arb_tbus_write_data),
      .icache2arb_tbus_write_mask     (icache2arb_tbus_write_mask),
      .icache2arb_tbus_operation_type (icache2arb_tbus_operation_type),
      .icache2arb_tbus_read_data      (icache2arb_tbus_read_data),
      .icache2arb_tbus_operation_done (icache2arb_tbus_operation_done),
      .dcache2arb_tbus_index_valid    (dcache2arb_tbus_index_valid),
      .dcache2arb_tbus_index_ready    (dcache2arb_tbus_index_ready),
      .dcache2arb_tbus_index          (dcache2arb_tbus_index),
      .dcache2arb_tbus_write_data     (dcache2arb_tbus_write_data),
      .dcache2arb_tbus_write_mask     (dcache2arb_tbus_write_mask),
      .dcache2arb_tbus_operation_type (dcache2arb_tbus_operation_type),
      .dcache2arb_tbus_read_data      (dcache2arb_tbus_read_data),
      .dcache2arb_tbus_operation_done (dcache2arb_tbus_operation_done),
      .arb2ddr_tbus_index_valid       (arb2ddr_tbus_index_valid),
      .arb2ddr_tbus_index_ready       (arb2ddr_tbus_index_ready),
      .arb2ddr_tbus_index             (arb2ddr_tbus_index),
      .arb2ddr_tbus_write_data        (arb2ddr_tbus_write_data),
      .arb2ddr_tbus_write_mask        (arb2ddr_tbus_write_mask),
      .arb2ddr_tbus_operation_type    (arb2ddr_tbus_operation_type),
      .arb2ddr_tbus_read_data         (arb2ddr_tbus_read_data),
      .arb2ddr_tbus_operation_done    (arb2ddr_tbus_operation_done),
      .arb_timeout_err                (arb_timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "bench time limit");
   end

   typedef struct {
      logic        iv, dv, exp_d, spur;
      logic [63:0] addr, wdata, mask, rdata;
      logic [1:0]  op;
      int          rd, dd;   // cycles DDR stalls ready; cycles from ready to done
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_rd_i, exp_rd_d;
   vec_t        vecs [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle_inputs();
      icache2arb_tbus_index_valid    = 1'b0;
      dcache2arb_tbus_index_valid    = 1'b0;
      icache2arb_tbus_index          = '0;
      icache2arb_tbus_write_data     = '0;
      icache2arb_tbus_write_mask     = '0;
      icache2arb_tbus_operation_type = '0;
      dcache2arb_tbus_index          = '0;
      dcache2arb_tbus_write_data     = '0;
      dcache2arb_tbus_write_mask     = '0;
      dcache2arb_tbus_operation_type = '0;
      arb2ddr_tbus_index_ready       = 1'b0;
      arb2ddr_tbus_operation_done    = 1'b0;
      arb2ddr_tbus_read_data         = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready_i"}, 64'(icache2arb_tbus_index_ready), 0);
      chk({tag, "_ready_d"}, 64'(dcache2arb_tbus_index_ready), 0);
      chk({tag, "_done_i"},  64'(icache2arb_tbus_operation_done), 0);
      chk({tag, "_done_d"},  64'(dcache2arb_tbus_operation_done), 0);
      chk({tag, "_rd_i"},    icache2arb_tbus_read_data, 0);
      chk({tag, "_rd_d"},    dcache2arb_tbus_read_data, 0);
      chk({tag, "_ddr_v"},   64'(arb2ddr_tbus_index_valid), 0);
      chk({tag, "_ddr_idx"}, arb2ddr_tbus_index, 0);
      chk({tag, "_ddr_wd"},  arb2ddr_tbus_write_data, 0);
      chk({tag, "_err"},     64'(arb_timeout_err), 0);
   endtask

   // Leaves the bench one ns after the first active edge with reset released.
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      drive_idle_inputs();
      exp_rd_i = '0;
      exp_rd_d = '0;
      #1;
      check_all_zero(tag);
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic chk_req(input vec_t v, input string tag);
      chk({tag, "_ddr_v"},   64'(arb2ddr_tbus_index_valid), 1);
      chk({tag, "_ddr_idx"}, arb2ddr_tbus_index, v.addr);
      chk({tag, "_ddr_wd"},  arb2ddr_tbus_write_data, v.wdata);
      chk({tag, "_ddr_wm"},  arb2ddr_tbus_write_mask, v.mask);
      chk({tag, "_ddr_op"},  64'(arb2ddr_tbus_operation_type), 64'(v.op));
   endtask

   // Winner gets the vector payload, the loser a scrambled one, so the DDR
   // payload must always equal the vector fields.
   task automatic run_vec(input vec_t v, input int id);
      string tag;
      tag = $sformatf("v%0d", id);
      icache2arb_tbus_index_valid = v.iv;
      dcache2arb_tbus_index_valid = v.dv;
      if (v.exp_d) begin
         dcache2arb_tbus_index = v.addr;  dcache2arb_tbus_write_data = v.wdata;
         dcache2arb_tbus_write_mask = v.mask; dcache2arb_tbus_operation_type = v.op;
         icache2arb_tbus_index = v.addr ^ 64'h1000; icache2arb_tbus_write_data = ~v.wdata;
         icache2arb_tbus_write_mask = v.mask ^ 64'hF0; icache2arb_tbus_operation_type = ~v.op;
      end else begin
         icache2arb_tbus_index = v.addr;  icache2arb_tbus_write_data = v.wdata;
         icache2arb_tbus_write_mask = v.mask; icache2arb_tbus_operation_type = v.op;
         dcache2arb_tbus_index = v.addr ^ 64'h1000; dcache2arb_tbus_write_data = ~v.wdata;
         dcache2arb_tbus_write_mask = v.mask ^ 64'hF0; dcache2arb_tbus_operation_type = ~v.op;
      end
      #1;
      chk({tag, "_ready_i"}, 64'(icache2arb_tbus_index_ready), 64'(!v.exp_d));
      chk({tag, "_ready_d"}, 64'(dcache2arb_tbus_index_ready), 64'(v.exp_d));
      @(posedge clock); #1;
      icache2arb_tbus_index_valid = 1'b0;
      dcache2arb_tbus_index_valid = 1'b0;
      for (int r = 0; r < v.rd; r++) begin
         arb2ddr_tbus_index_ready    = 1'b0;
         arb2ddr_tbus_operation_done = v.spur && (r == 0);
         arb2ddr_tbus_read_data      = 64'hBAD0_BAD0;
         #1;
         chk_req(v, $sformatf("%s_stall%0d", tag, r));
         @(posedge clock); #1;
      end
      arb2ddr_tbus_index_ready    = 1'b1;
      arb2ddr_tbus_operation_done = (v.dd == 0);
      arb2ddr_tbus_read_data      = (v.dd == 0) ? v.rdata : 64'hBAD0_BAD0;
      #1;
      chk_req(v, {tag, "_acc"});
      @(posedge clock); #1;
      arb2ddr_tbus_index_ready    = 1'b0;
      arb2ddr_tbus_operation_done = 1'b0;
      for (int k = 1; k <= v.dd; k++) begin
         chk({tag, "_wait_ddr_v"}, 64'(arb2ddr_tbus_index_valid), 0);
         chk({tag, "_wait_done"},
             64'(icache2arb_tbus_operation_done | dcache2arb_tbus_operation_done), 0);
         arb2ddr_tbus_operation_done = (k == v.dd);
         arb2ddr_tbus_read_data      = (k == v.dd) ? v.rdata : 64'hBAD0_BAD0;
         @(posedge clock); #1;
         arb2ddr_tbus_operation_done = 1'b0;
      end
      if (v.exp_d) exp_rd_d = v.rdata;
      else         exp_rd_i = v.rdata;
      chk({tag, "_done_i"}, 64'(icache2arb_tbus_operation_done), 64'(!v.exp_d));
      chk({tag, "_done_d"}, 64'(dcache2arb_tbus_operation_done), 64'(v.exp_d));
      chk({tag, "_rd_i"},   icache2arb_tbus_read_data, exp_rd_i);
      chk({tag, "_rd_d"},   dcache2arb_tbus_read_data, exp_rd_d);
      @(posedge clock); #1;
      chk({tag, "_post_done"},
          64'(icache2arb_tbus_operation_done | dcache2arb_tbus_operation_done), 0);
      chk({tag, "_post_ddr_v"}, 64'(arb2ddr_tbus_index_valid), 0);
   endtask

   initial begin
      //                iv  dv  exp_d spur addr              wdata      mask   rdata          op    rd dd
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0040, 64'h0,     64'h0,  64'hDEAD_BEEF, 2'd0, 0, 3};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_2000, 64'h1122,  64'hFF, 64'h55,        2'd1, 5, 1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_0040, 64'h0,     64'h0,  64'h1234,      2'd0, 0, 0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0000_3000, 64'h77,    64'h0F, 64'hA5A5,      2'd2, 1, 2};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_4000, 64'h88,    64'hF0, 64'h5A5A,      2'd3, 0, 0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0000_5000, 64'h99,    64'h3C, 64'hC3,        2'd1, 2, 0};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0000_6000, 64'hAA,    64'hC3, 64'h3C,        2'd2, 0, 1};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_7000, 64'hBB,    64'h01, 64'h99,        2'd0, 0, 0};

      do_reset("rst0");

      // Both masters held valid from the first cycle after reset; DDR answers
      // ready+done immediately, so each transaction spans IDLE/REQ/RESP.
      icache2arb_tbus_index_valid = 1'b1;
      dcache2arb_tbus_index_valid = 1'b1;
      icache2arb_tbus_index       = 64'h100;
      dcache2arb_tbus_index       = 64'h200;
      arb2ddr_tbus_index_ready    = 1'b1;
      arb2ddr_tbus_operation_done = 1'b1;
      arb2ddr_tbus_read_data      = 64'h77;
      for (int c = 0; c < 9; c++) begin
         #1;
         chk($sformatf("rr%0d_ready_i", c), 64'(icache2arb_tbus_index_ready), 64'(c == 0 || c == 6));
         chk($sformatf("rr%0d_ready_d", c), 64'(dcache2arb_tbus_index_ready), 64'(c == 3));
         chk($sformatf("rr%0d_done_i", c), 64'(icache2arb_tbus_operation_done), 64'(c == 2 || c == 8));
         chk($sformatf("rr%0d_done_d", c), 64'(dcache2arb_tbus_operation_done), 64'(c == 5));
         chk($sformatf("rr%0d_ddr_v", c), 64'(arb2ddr_tbus_index_valid), 64'(c % 3 == 1));
         if (c % 3 == 1)
            chk($sformatf("rr%0d_ddr_idx", c), arb2ddr_tbus_index, (c == 4) ? 64'h200 : 64'h100);
         @(posedge clock); #1;
      end

      do_reset("rst1");
      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset asserted mid-cycle while an icache transaction sits in WAIT.
      icache2arb_tbus_index_valid = 1'b1;
      icache2arb_tbus_index       = 64'h9000;
      #1;
      chk("rw_ready_i", 64'(icache2arb_tbus_index_ready), 1);
      @(posedge clock); #1;
      icache2arb_tbus_index_valid = 1'b0;
      arb2ddr_tbus_index_ready    = 1'b1;
      @(posedge clock); #1;
      arb2ddr_tbus_index_ready    = 1'b0;
      chk("rw_wait_ddr_v", 64'(arb2ddr_tbus_index_valid), 0);
      #2;
      reset_n = 1'b0;
      icache2arb_tbus_index_valid = 1'b1;
      dcache2arb_tbus_index_valid = 1'b1;
      exp_rd_i = '0;
      exp_rd_d = '0;
      #1;
      check_all_zero("rw_async");
      @(posedge clock); #1;
      reset_n = 1'b1;
      #1;
      chk("rw_first_ready_i", 64'(icache2arb_tbus_index_ready), 1);
      chk("rw_first_ready_d", 64'(dcache2arb_tbus_index_ready), 0);
      @(posedge clock); #1;
      icache2arb_tbus_index_valid = 1'b0;
      dcache2arb_tbus_index_valid = 1'b0;
      arb2ddr_tbus_index_ready    = 1'b1;
      arb2ddr_tbus_operation_done = 1'b1;
      arb2ddr_tbus_read_data      = 64'h4242;
      #1;
      chk("rw_req_ddr_v", 64'(arb2ddr_tbus_index_valid), 1);
      @(posedge clock); #1;
      arb2ddr_tbus_index_ready    = 1'b0;
      arb2ddr_tbus_operation_done = 1'b0;
      chk("rw_done_i", 64'(icache2arb_tbus_operation_done), 1);
      chk("rw_rd_i",   icache2arb_tbus_read_data, 64'h4242);
      chk("rw_rd_d",   dcache2arb_tbus_read_data, 0);
      @(posedge clock); #1;

`ifdef TBUS_ARB_TIMEOUT_EN
      begin
         int lat;
         icache2arb_tbus_index_valid = 1'b1;
         #1;
         @(posedge clock); #1;
         icache2arb_tbus_index_valid = 1'b0;
         arb2ddr_tbus_index_ready    = 1'b1;
         lat = 1;
         @(posedge clock); #1;
         arb2ddr_tbus_index_ready    = 1'b0;
         lat = 2;
         while (!icache2arb_tbus_operation_done && lat < 60) begin
            @(posedge clock); #1;
            lat++;
         end
         chk("to_latency", 64'(lat), 64'(TO_CYC + 1));
         chk("to_rd_i", icache2arb_tbus_read_data, 64'hFFFF_FFFF_FFFF_FFFF);
         chk("to_err",  64'(arb_timeout_err), 1);
         repeat (5) @(posedge clock);
         #1;
         chk("to_err_sticky", 64'(arb_timeout_err), 1);
         do_reset("to_rst");
      end
`else
      chk("err_tied_low", 64'(arb_timeout_err), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tbus_arbiter.md
Name: tbus_arbiter

Overview:
Two-master, one-slave arbiter on the trinity bus (tbus), sitting directly downstream of the icache and dcache miss/writeback ports and upstream of the DDR controller port.
- Accepts one request at a time from either cache, using round-robin on contention.
- Forwards the request to DDR from registered copies of the payload.
- Returns the read data and a one-cycle operation_done pulse to the owning master only.
- One transaction outstanding at a time; no pipelining across masters.

Parameters:
ADDR_WIDTH, 64, width of tbus_index.
DATA_WIDTH, 64, width of write_data, write_mask and read_data.
OP_WIDTH, 2, width of tbus_operation_type (passed through, not decoded).
TIMEOUT_CYCLES, 1024, watchdog limit; used only with TBUS_ARB_TIMEOUT_EN.

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
<m>_tbus_index_valid  in  1  request valid, for <m> in {icache2arb, dcache2arb}
<m>_tbus_index_ready  out  1  request accepted this cycle
<m>_tbus_index  in  ADDR_WIDTH  request address
<m>_tbus_write_data  in  DATA_WIDTH  write data
<m>_tbus_write_mask  in  DATA_WIDTH  write byte/bit mask
<m>_tbus_operation_type  in  OP_WIDTH  read/write type
<m>_tbus_read_data  out  DATA_WIDTH  returned read data
<m>_tbus_operation_done  out  1  one-cycle completion pulse
arb2ddr_tbus_index_valid  out  1  request to DDR
arb2ddr_tbus_index_ready  in  1  DDR accepts request
arb2ddr_tbus_index / _write_data / _write_mask / _operation_type  out  ADDR/DATA/DATA/OP widths  registered payload
arb2ddr_tbus_read_data  in  DATA_WIDTH  DDR read data
arb2ddr_tbus_operation_done  in  1  DDR completion pulse
arb_timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: asynchronous on reset_n low. State goes to IDLE; every output goes to 0; last_grant resets to dcache, so icache wins the first tie. Any in-flight transaction is dropped and arb2ddr valid falls immediately.
- States: IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE:
  - If exactly one master's valid is high, that master is granted.
  - If both are high, the master that is not last_grant is granted.
  - The granted master's index_ready is combinationally high in that same cycle. Payload, owner ID and last_grant are latched at the clock edge. Next state is REQ.
  - index_ready is never high outside IDLE, and never high for both masters at once.
- REQ:
  - arb2ddr valid is high, driven from the latched payload; the payload is stable until ready.
  - On ddr ready, go to WAIT.
  - If ddr ready and ddr done are high in the same cycle, capture read_data and go straight to RESP.
- WAIT: on ddr done, capture arb2ddr read_data into the owner's read_data register and go to RESP. A done pulse arriving in REQ without ready is ignored.
- RESP:
  - The owner's operation_done is high for exactly this one cycle.
  - Its read_data holds the captured value until that master's next completion. For writes, read_data takes whatever DDR returned.
  - The non-owner's outputs are unchanged. Next state is IDLE.
- Turnaround: earliest next grant is the cycle after RESP.
- Minimum latency: master valid at cycle N, ddr valid at N+1, ddr ready+done at N+1, master done at N+2.
- A master's valid held through its own done pulse is treated as a new request in the next IDLE.

Optional Feature:
TBUS_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on leaving IDLE and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without ddr done, the block drops arb2ddr valid and goes to RESP.
  - In that RESP the owner's done pulse is delivered with read_data = all ones, and arb_timeout_err is set.
  - arb_timeout_err is sticky and cleared only by reset.
  - A ddr done in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter; the block waits indefinitely; arb_timeout_err is tied to 0.

Test Plan:
1. icache-only read, addr 0x8000_0040; DDR ready at N+1, done at N+4 with data 0xDEAD_BEEF -> icache done pulse at N+5 with read_data 0xDEAD_BEEF; dcache outputs remain 0.
2. Both masters valid at the first cycle after reset -> icache granted first, dcache granted in the IDLE after icache's RESP. Repeated contention alternates grants.
3. dcache write, data 0x1122, mask 0xFF; DDR holds ready low for 5 cycles -> arb2ddr payload stable and valid high throughout; done pulse exactly 1 cycle.
4. DDR asserts ready and done in the same cycle as the first REQ cycle -> master done exactly 2 cycles after its request was accepted.
5. reset_n pulsed low during WAIT -> all outputs 0 asynchronously; next request behaves as in the first cycle after reset.
6. (TBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) DDR never asserts done -> done pulse with read_data all ones after 16 cycles; arb_timeout_err stays 1 until reset.
